// File: rtl/mips_dmem_responder.sv
// Single-word data-memory responder for the mips core with a fixed wait-state latency.
// One request in flight; the response is a one-cycle pulse with registered data and error flag.
module mips_dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT     = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state_reg;
  logic [3:0]    cnt_reg;
  logic          write_reg;
  logic [31:0]   addr_reg;
  logic [31:0]   wdata_reg;
  logic [3:0]    be_reg;

  logic          accept;
  logic          go_resp;
  logic [31:0]   sel_addr;
  logic          sel_write;
  logic          sel_err;
  logic          rd_en;
  logic          commit;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;

  // With zero wait states the response is entered straight from IDLE, so the
  // live request fields are used instead of the captured ones.
  assign accept    = req_valid & req_ready;
  assign sel_addr  = (state_reg == S_IDLE) ? req_addr : addr_reg;
  assign sel_write = (state_reg == S_IDLE) ? req_write : write_reg;
  assign sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr >= LIMIT);
  assign go_resp   = (accept && (WAIT_CYCLES == 0)) ||
                     ((state_reg == S_WAIT) && (cnt_reg == 4'd1));
  assign rd_en     = go_resp && !sel_write && !sel_err;
  assign commit    = (state_reg == S_RESP) && write_reg && !resp_err && !rst;
  assign rd_idx    = sel_addr[AW+1:2];
  assign wr_idx    = addr_reg[AW+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= 4'd0;
      write_reg  <= 1'b0;
      addr_reg   <= 32'd0;
      wdata_reg  <= 32'd0;
      be_reg     <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            write_reg <= req_write;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            be_reg    <= req_be;
            cnt_reg   <= WAIT_INIT;
            req_ready <= 1'b0;
            if (go_resp) begin
              state_reg  <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= sel_err;
            end else begin
              state_reg <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (go_resp) begin
            state_reg  <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= sel_err;
          end
        end
        S_RESP: begin
          state_reg  <= S_IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: begin
          state_reg  <= S_IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

  // One byte-wide RAM per lane so byte enables map onto independent write ports.
  // The read register is zeroed outside the response cycle, which keeps
  // resp_rdata at 0 for stores, errors and idle cycles.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem_lane [DEPTH_WORDS];
      logic [7:0] rd_lane_reg;

      always_ff @(posedge clk) begin
        if (commit && be_reg[gi]) begin
          mem_lane[wr_idx] <= wdata_reg[8*gi +: 8];
        end
      end

      always_ff @(posedge clk) begin
        if (rst || !rd_en) begin
          rd_lane_reg <= 8'd0;
        end else begin
          rd_lane_reg <= mem_lane[rd_idx];
        end
      end

      assign resp_rdata[8*gi +: 8] = rd_lane_reg;
    end
  endgenerate

endmodule
